sim_ctrl: RTL

Simulation run controller that produces the `finish` request consumed by the top-level model. It sequences a run: wait for start, count run cycles, end on an explicit done request or an optional watchdog timeout, drain for a fixed number of cycles, then assert `finish` and hold it. It sits in the Verilator bench beside the model under test and drives that model's `finish` input directly.

---
 rtl/sim_ctrl_pkg.sv | 15 +
 rtl/sim_ctrl_sat_cnt.sv | 43 ++++
 rtl/sim_ctrl.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/sim_ctrl_pkg.sv
// sim_ctrl_pkg
// Shared definitions for the simulation run controller: the FSM state
// encoding (also exported on the debug `state` port) and its width.
package sim_ctrl_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_e;

endpackage

// File: rtl/sim_ctrl_sat_cnt.sv
// sim_ctrl_sat_cnt
// Up-counter with synchronous clear, count enable and saturation at all-ones.
// Ports:
//   clk   - clock, posedge
//   rst_n - synchronous active-low reset (count -> 0)
//   clr   - synchronous clear, has priority over en
//   en    - count enable
//   cnt   - registered count value
module sim_ctrl_sat_cnt
  import sim_ctrl_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/sim_ctrl.sv
// sim_ctrl
// Simulation run controller: waits for `start`, counts RUN cycles, ends the
// run on `done_req` (or on the watchdog when built with SIM_CTRL_TIMEOUT_EN),
// drains for DRAIN_CYCLES cycles and then raises a sticky `finish`.
// Optional feature macro: SIM_CTRL_TIMEOUT_EN (watchdog + `timeout` output).
// Ports:
//   clk       - clock, posedge
//   rst_n     - synchronous active-low reset
//   start     - begin a run (sampled in IDLE only)
//   done_req  - request normal end of run (sampled in RUN only)
//   finish    - sticky run-complete flag
//   running   - high while in RUN
//   timeout   - sticky, run ended by the watchdog (0 without the macro)
//   heartbeat - one-cycle pulse every HB_PERIOD RUN cycles
//   cycle_cnt - saturating count of RUN cycles
//   state     - current FSM state (debug)
module sim_ctrl
  import sim_ctrl_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int MAX_CYCLES   = 1000,
  parameter int DRAIN_CYCLES = 4,
  parameter int HB_PERIOD    = 100
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               done_req,
  output logic               finish,
  output logic               running,
  output logic               timeout,
  output logic               heartbeat,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic [STATE_W-1:0] state
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int HB_W    = (HB_PERIOD > 1) ? $clog2(HB_PERIOD) : 1;
  // Terminal values; clamped to 0 when the feature is disabled so the
  // constants stay in range.
  localparam logic [DRAIN_W-1:0] DRAIN_LAST =
    DRAIN_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);
  localparam logic [HB_W-1:0] HB_LAST =
    HB_W'((HB_PERIOD > 0) ? HB_PERIOD - 1 : 0);

  if (MAX_CYCLES < 1) begin : g_bad_max_cycles
    $error("sim_ctrl: MAX_CYCLES must be >= 1");
  end

  state_e            state_q, state_d;
  logic              finish_q, finish_d;
  logic              running_q, running_d;
  logic              heartbeat_q, heartbeat_d;
  logic [HB_W-1:0]   hb_cnt_q, hb_cnt_d;
  logic              cyc_clr, cyc_en;
  logic              drain_clr, drain_en;
  logic [DRAIN_W-1:0] drain_cnt;
  logic              wd_hit;

`ifdef SIM_CTRL_TIMEOUT_EN
  logic timeout_q, timeout_d;
  // Fires on the last allowed RUN edge so the run lasts exactly MAX_CYCLES.
  assign wd_hit  = (cycle_cnt == CNT_W'(MAX_CYCLES - 1));
  assign timeout = timeout_q;
`else
  assign wd_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  sim_ctrl_sat_cnt #(.W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cyc_clr),
    .en    (cyc_en),
    .cnt   (cycle_cnt)
  );

  sim_ctrl_sat_cnt #(.W(DRAIN_W)) u_drain_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (drain_clr),
    .en    (drain_en),
    .cnt   (drain_cnt)
  );

  always_comb begin
    state_d     = state_q;
    finish_d    = finish_q;
    running_d   = running_q;
    hb_cnt_d    = hb_cnt_q;
    heartbeat_d = 1'b0;
    cyc_clr     = 1'b0;
    cyc_en      = 1'b0;
    // Drain counter idles at 0 and only counts while draining.
    drain_clr   = (state_q != ST_DRAIN);
    drain_en    = (state_q == ST_DRAIN);
`ifdef SIM_CTRL_TIMEOUT_EN
    timeout_d   = timeout_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_RUN;
          running_d = 1'b1;
          cyc_clr   = 1'b1;
          hb_cnt_d  = '0;
        end
      end

      ST_RUN: begin
        // Counting continues on the exit edge so the final count equals
        // the number of RUN cycles.
        cyc_en = 1'b1;
        if (HB_PERIOD > 0) begin
          if (hb_cnt_q == HB_LAST) begin
            hb_cnt_d    = '0;
            heartbeat_d = 1'b1;
          end else begin
            hb_cnt_d = hb_cnt_q + HB_W'(1);
          end
        end
        if (done_req || wd_hit) begin
          running_d = 1'b0;
`ifdef SIM_CTRL_TIMEOUT_EN
          // done_req wins over a simultaneous watchdog hit.
          if (!done_req) begin
            timeout_d = 1'b1;
          end
`endif
          if (DRAIN_CYCLES > 0) begin
            state_d = ST_DRAIN;
          end else begin
            state_d  = ST_FINISH;
            finish_d = 1'b1;
          end
        end
      end

      ST_DRAIN: begin
        if (drain_cnt == DRAIN_LAST) begin
          state_d  = ST_FINISH;
          finish_d = 1'b1;
        end
      end

      ST_FINISH: begin
        finish_d = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      finish_q    <= 1'b0;
      running_q   <= 1'b0;
      heartbeat_q <= 1'b0;
      hb_cnt_q    <= '0;
`ifdef SIM_CTRL_TIMEOUT_EN
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      finish_q    <= finish_d;
      running_q   <= running_d;
      heartbeat_q <= heartbeat_d;
      hb_cnt_q    <= hb_cnt_d;
`ifdef SIM_CTRL_TIMEOUT_EN
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign finish    = finish_q;
  assign running   = running_q;
  assign heartbeat = heartbeat_q;
  assign state     = state_q;

endmodule
